// File: rtl/weight_stream_sequencer_pkg.sv
// Shared definitions for the kernel-weight stream sequencer: FSM encoding
// and the ROM address width helper.
package weight_stream_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // A one-entry ROM still needs a one-bit address port.
    function automatic int addr_w(input int mem_size);
        return (mem_size > 1) ? $clog2(mem_size) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry FIFO used as the output skid buffer of stream controllers.
// A push and a pop in the same cycle leave the occupancy unchanged.
module stream_skid_buf2 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Pops on an empty buffer and pushes into a full one are ignored.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = rd_ptr ? entry1 : entry0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) begin
                    entry1 <= push_data;
                end else begin
                    entry0 <= push_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_stream_sequencer.sv
// Streams the full kernel-weight ROM n_passes times into the weight FIFO,
// with the ap_start/ap_ready/ap_idle/ap_done layer handshake.
module weight_stream_sequencer
    import weight_stream_sequencer_pkg::*;
#(
    parameter int MEM_SIZE   = 9,
    parameter int DATA_WIDTH = 16,
    parameter int PASS_WIDTH = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          ap_start,
    input  logic [PASS_WIDTH-1:0]         n_passes,
    output logic                          ap_ready,
    output logic                          ap_idle,
    output logic                          ap_done,
    output logic [addr_w(MEM_SIZE)-1:0]   weight_address,
    output logic                          weight_ce,
    input  logic [DATA_WIDTH-1:0]         weight_q,
    output logic [DATA_WIDTH-1:0]         output_V_din,
    input  logic                          output_V_full_n,
    output logic                          output_V_write
);

    localparam int ADDR_W = addr_w(MEM_SIZE);
    localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
    localparam logic [ADDR_W-1:0]     ADDR_ONE  = ADDR_W'(1);
    localparam logic [PASS_WIDTH-1:0] PASS_ONE  = PASS_WIDTH'(1);

    seq_state_t            state;
    logic [PASS_WIDTH-1:0] passes_lat;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic                  inflight;
    logic [1:0]            buf_count;
    logic                  buf_pop;
    logic [2:0]            backlog;
    logic                  last_read;
    logic                  drain_empty;

    // The word requested last cycle arrives now and is pushed unconditionally.
    stream_skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid_buf (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .push      (inflight),
        .push_data (weight_q),
        .pop       (buf_pop),
        .count     (buf_count),
        .head      (output_V_din)
    );

    assign buf_pop        = (buf_count != 2'd0) && output_V_full_n;
    assign output_V_write = buf_pop;
    assign ap_ready       = (state == ST_IDLE) && ap_start;

    // Counting the same-cycle pop lets the stream sustain one word per cycle
    // while still leaving room for every word already requested.
    assign backlog     = {1'b0, buf_count} + {2'b00, inflight};
    assign weight_ce   = (state == ST_RUN) && (backlog <= (3'd1 + {2'b00, buf_pop}));
    assign last_read   = weight_ce && (weight_address == LAST_ADDR)
                         && (pass_cnt == (passes_lat - PASS_ONE));
    assign drain_empty = !inflight
                         && ((buf_count == 2'd0) || ((buf_count == 2'd1) && buf_pop));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state          <= ST_IDLE;
            ap_idle        <= 1'b1;
            ap_done        <= 1'b0;
            passes_lat     <= '0;
            pass_cnt       <= '0;
            weight_address <= '0;
            inflight       <= 1'b0;
        end else begin
            inflight <= weight_ce;
            ap_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        passes_lat     <= n_passes;
                        pass_cnt       <= '0;
                        weight_address <= '0;
                        ap_idle        <= 1'b0;
                        if (n_passes == '0) begin
                            state   <= ST_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (weight_ce) begin
                        if (weight_address == LAST_ADDR) begin
                            weight_address <= '0;
                            pass_cnt       <= pass_cnt + PASS_ONE;
                        end else begin
                            weight_address <= weight_address + ADDR_ONE;
                        end
                    end
                    if (last_read) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state   <= ST_DONE;
                        ap_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule
